// File: rtl/mar_mbr_mem_if.sv
// Memory access stage: owns MAR/MBR and runs one req/ack read or write
// transaction on external memory, aborting with err after TMO_CYC cycles.
//
//   state | meaning
//   IDLE  | accepts MAR/MBR loads and rd_start/wr_start
//   REQ   | mem_req high, waiting for mem_ack or timeout
//   DONE  | one-cycle done pulse, MBR holds read data
//   ABORT | one-cycle err pulse, MBR unchanged
module mar_mbr_mem_if #(
    parameter int ADDR_W  = 8,
    parameter int DATA_W  = 16,
    parameter int TMO_CYC = 15
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              C_mar_pc,
    input  logic              C_mar_mbr,
    input  logic              rd_start,
    input  logic              wr_start,
    input  logic              C_mbr_acc,
    input  logic [ADDR_W-1:0] PC_in,
    input  logic [DATA_W-1:0] ACC_in,
    output logic [ADDR_W-1:0] MAR_out,
    output logic [DATA_W-1:0] MBR_out,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ack
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        REQ   = 2'd1,
        DONE  = 2'd2,
        ABORT = 2'd3
    } state_t;

    localparam logic [7:0] TMO_LAST = 8'(TMO_CYC - 1);

    state_t            state, state_nxt;
    logic [7:0]        wait_cnt;
    logic [ADDR_W-1:0] mar, req_addr;
    logic [DATA_W-1:0] mbr, req_wdata;
    logic              req_we;
    logic              start;
    logic              timeout;

    assign start   = rd_start | wr_start;
    // wait_cnt equals the number of REQ cycles already completed
    assign timeout = (wait_cnt == TMO_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        busy      = 1'b0;
        done      = 1'b0;
        err       = 1'b0;
        mem_req   = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = REQ;
                end
            end
            REQ: begin
                busy    = 1'b1;
                mem_req = 1'b1;
                // ack wins over a coincident timeout
                if (mem_ack) begin
                    state_nxt = DONE;
                end else if (timeout) begin
                    state_nxt = ABORT;
                end
            end
            DONE: begin
                busy      = 1'b1;
                done      = 1'b1;
                state_nxt = IDLE;
            end
            ABORT: begin
                busy      = 1'b1;
                err       = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Address/data are snapshotted at start so a same-cycle MAR/MBR load
    // cannot disturb the transaction that is being launched.
    always_ff @(posedge clk) begin
        if (rst) begin
            mar       <= '0;
            mbr       <= '0;
            req_addr  <= '0;
            req_wdata <= '0;
            req_we    <= 1'b0;
            wait_cnt  <= '0;
        end else begin
            if (state == REQ) begin
                wait_cnt <= wait_cnt + 8'd1;
            end else begin
                wait_cnt <= '0;
            end

            if (state == IDLE) begin
                if (start) begin
                    req_we    <= wr_start;
                    req_addr  <= mar;
                    req_wdata <= mbr;
                end
                if (C_mar_pc) begin
                    mar <= PC_in;
                end else if (C_mar_mbr) begin
                    mar <= mbr[ADDR_W-1:0];
                end
                if (C_mbr_acc) begin
                    mbr <= ACC_in;
                end
            end else if (state == REQ && mem_ack && !req_we) begin
                mbr <= mem_rdata;
            end
        end
    end

    assign MAR_out   = mar;
    assign MBR_out   = mbr;
    assign mem_we    = mem_req & req_we;
    assign mem_addr  = mem_req ? req_addr : '0;
    assign mem_wdata = mem_req ? req_wdata : '0;

endmodule

// File: tb/tb_mar_mbr_mem_if.sv
// Randomized bench for mar_mbr_mem_if: a transaction-level model predicts each
// completion into a scoreboard that a negedge monitor drains.
module tb_mar_mbr_mem_if;
    localparam int AW  = 8;
    localparam int DW  = 16;
    localparam int TMO = 15;

    logic          clk = 1'b0;
    logic          rst;
    logic          C_mar_pc, C_mar_mbr, rd_start, wr_start, C_mbr_acc;
    logic [AW-1:0] PC_in;
    logic [DW-1:0] ACC_in;
    logic [AW-1:0] MAR_out;
    logic [DW-1:0] MBR_out;
    logic          busy, done, err;
    logic          mem_req, mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;
    logic          mem_ack;

    mar_mbr_mem_if #(.ADDR_W(AW), .DATA_W(DW), .TMO_CYC(TMO)) dut (
        .clk(clk), .rst(rst),
        .C_mar_pc(C_mar_pc), .C_mar_mbr(C_mar_mbr),
        .rd_start(rd_start), .wr_start(wr_start), .C_mbr_acc(C_mbr_acc),
        .PC_in(PC_in), .ACC_in(ACC_in),
        .MAR_out(MAR_out), .MBR_out(MBR_out),
        .busy(busy), .done(done), .err(err),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        bit            we;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        bit            ok;
        logic [DW-1:0] mbr;
        int            waits;
        int            issue_cyc;
    } exp_t;

    exp_t sb[$];
    int n_tests = 0;
    int n_fail  = 0;

    logic [AW-1:0] m_mar;
    logic [DW-1:0] m_mbr;
    logic [DW-1:0] m_mem [256];
    logic [DW-1:0] env_mem [256];
    int resp_waits = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Memory responder: acks after resp_waits REQ cycles; stray acks while idle.
    int k = 0;
    always @(negedge clk) begin
        if (mem_req) begin
            mem_rdata = env_mem[mem_addr];
            if (k == resp_waits) begin
                mem_ack = 1'b1;
                if (mem_we) env_mem[mem_addr] = mem_wdata;
            end else begin
                mem_ack = 1'b0;
            end
            k++;
        end else begin
            k = 0;
            mem_rdata = DW'($urandom);
            mem_ack = ($urandom_range(0, 3) == 0);
        end
    end

    // Monitor: checks handshake fields during REQ and pops on each completion.
    int req_len = 0;
    exp_t e_mon;
    always @(negedge clk) begin
        if (rst) begin
            req_len = 0;
        end else begin
            if (mem_req) begin
                req_len++;
                chk("txn_outstanding_req", 32'(sb.size() != 0), 1);
                if (sb.size() != 0) begin
                    chk("mem_we", 32'(mem_we), 32'(sb[0].we));
                    chk("mem_addr", 32'(mem_addr), 32'(sb[0].addr));
                    chk("mem_wdata", 32'(mem_wdata), 32'(sb[0].wdata));
                end
            end
            if (done || err) begin
                chk("done_and_err", 32'(done && err), 0);
                chk("txn_outstanding_cpl", 32'(sb.size() != 0), 1);
                if (sb.size() != 0) begin
                    e_mon = sb.pop_front();
                    chk("result_ok", 32'(done), 32'(e_mon.ok));
                    chk("mbr_after", 32'(MBR_out), 32'(e_mon.mbr));
                    chk("req_cycles", 32'(req_len), 32'(e_mon.ok ? e_mon.waits + 1 : TMO));
                    chk("latency", 32'(cyc - e_mon.issue_cyc),
                        32'(e_mon.ok ? e_mon.waits + 2 : TMO + 1));
                end
                req_len = 0;
            end
        end
    end

    task automatic drive_idle();
        C_mar_pc = 0; C_mar_mbr = 0; C_mbr_acc = 0; rd_start = 0; wr_start = 0;
    endtask

    // Drives one IDLE cycle of controls and updates the model; a start uses the
    // pre-load MAR/MBR.
    task automatic drive_start(input bit ld_pc, input bit ld_mm, input bit ld_acc,
                               input bit rd, input bit wr, input logic [AW-1:0] pc,
                               input logic [DW-1:0] acc, input int waits);
        exp_t e;
        logic [AW-1:0] old_mar;
        logic [DW-1:0] old_mbr, new_mbr;
        old_mar = m_mar;
        old_mbr = m_mbr;
        C_mar_pc = ld_pc; C_mar_mbr = ld_mm; C_mbr_acc = ld_acc;
        rd_start = rd; wr_start = wr; PC_in = pc; ACC_in = acc;
        resp_waits = waits;
        if (ld_pc) m_mar = pc;
        else if (ld_mm) m_mar = old_mbr[AW-1:0];
        new_mbr = ld_acc ? acc : old_mbr;
        if (rd || wr) begin
            e.we = wr;
            e.addr = old_mar;
            e.wdata = old_mbr;
            e.ok = (waits < TMO);
            e.waits = waits;
            e.issue_cyc = cyc;
            e.mbr = (!wr && e.ok) ? m_mem[old_mar] : new_mbr;
            if (wr && e.ok) m_mem[old_mar] = old_mbr;
            m_mbr = e.mbr;
            sb.push_back(e);
        end else begin
            m_mbr = new_mbr;
        end
    endtask

    // Random control noise while busy must be ignored.
    task automatic wait_idle();
        bit idle_seen;
        idle_seen = 0;
        for (int i = 0; i < 100; i++) begin
            if (!busy) begin
                idle_seen = 1;
                break;
            end
            C_mar_pc = 1'($urandom); C_mar_mbr = 1'($urandom); C_mbr_acc = 1'($urandom);
            rd_start = 1'($urandom); wr_start = 1'($urandom);
            PC_in = AW'($urandom); ACC_in = DW'($urandom);
            @(posedge clk); #1;
        end
        drive_idle();
        chk("idle_reached", 32'(idle_seen), 1);
        chk("MAR_idle", 32'(MAR_out), 32'(m_mar));
        chk("MBR_idle", 32'(MBR_out), 32'(m_mbr));
        chk("sb_drained", 32'(sb.size()), 0);
    endtask

    task automatic issue(input bit ld_pc, input bit ld_mm, input bit ld_acc,
                         input bit rd, input bit wr, input logic [AW-1:0] pc,
                         input logic [DW-1:0] acc, input int waits);
        drive_start(ld_pc, ld_mm, ld_acc, rd, wr, pc, acc, waits);
        @(posedge clk); #1;
        wait_idle();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int r, w, op;
        rst = 1'b1;
        drive_idle();
        PC_in = '0; ACC_in = '0;
        for (int i = 0; i < 256; i++) begin
            m_mem[i] = DW'($urandom);
            env_mem[i] = m_mem[i];
        end
        m_mar = '0;
        m_mbr = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_MAR", 32'(MAR_out), 0);
        chk("rst_MBR", 32'(MBR_out), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_done_err", 32'({done, err}), 0);
        chk("rst_mem_req", 32'({mem_req, mem_we}), 0);
        chk("rst_mem_bus", 32'({mem_addr, mem_wdata}), 0);
        rst = 1'b0;

        // zero-wait read from PC-loaded address
        m_mem[8'h05] = 16'hA3C7;
        env_mem[8'h05] = 16'hA3C7;
        issue(1, 0, 0, 0, 0, 8'h05, '0, 0);
        issue(0, 0, 0, 1, 0, '0, '0, 0);
        chk("t1_MBR", 32'(MBR_out), 32'h0000_A3C7);
        // load in the start cycle: read uses old MAR (05)
        issue(1, 0, 0, 1, 0, 8'h20, '0, 2);
        // write 1234 to 10 with 3 waits
        issue(1, 0, 0, 0, 0, 8'h10, '0, 0);
        issue(0, 0, 1, 0, 0, '0, 16'h1234, 0);
        issue(0, 0, 0, 0, 1, '0, '0, 3);
        chk("t2_mem10", 32'(env_mem[8'h10]), 32'h0000_1234);
        // timeout, then simultaneous rd/wr, then ack in the timeout cycle
        issue(0, 0, 0, 1, 0, '0, '0, TMO + 3);
        issue(0, 0, 0, 1, 1, '0, '0, 1);
        issue(0, 0, 0, 1, 0, '0, '0, TMO - 1);
        issue(0, 1, 0, 1, 0, '0, '0, 0);

        // reset in the middle of a REQ
        drive_start(0, 0, 0, 1, 0, '0, '0, 1000);
        @(posedge clk); #1;
        drive_idle();
        repeat (3) @(posedge clk);
        #1;
        chk("pre_rst_req", 32'(mem_req), 1);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        sb.delete();
        m_mar = '0;
        m_mbr = '0;
        chk("midrst_MAR", 32'(MAR_out), 0);
        chk("midrst_MBR", 32'(MBR_out), 0);
        chk("midrst_req", 32'(mem_req), 0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("midrst_no_pulse", 32'({done, err, busy}), 0);
        end
        @(posedge clk); #1;

        for (int n = 0; n < 300; n++) begin
            r = $urandom_range(0, 9);
            if (r < 7) w = $urandom_range(0, 4);
            else if (r < 9) w = $urandom_range(5, TMO - 1);
            else w = $urandom_range(TMO, TMO + 4);
            op = $urandom_range(0, 3);
            issue(($urandom_range(0, 2) == 0), ($urandom_range(0, 2) == 0),
                  ($urandom_range(0, 2) == 0), op[0], op[1],
                  AW'($urandom), DW'($urandom), w);
        end

        repeat (5) @(posedge clk);
        chk("final_sb_empty", 32'(sb.size()), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
